input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioning stage for the board's push-buttons and slide switches. Takes raw asynchronous BTN_WEST, BTN_EAST and SW[3:0], as driven by the pads or by the top-level stimulus bench, and synchronizes them into the CLK50MHZ domain. It debounces each line and emits clean levels plus single-cycle event pulses for the downstream control logic.

## Interface

Parameters:
- STABLE, 8: consecutive cycles a synchronized input must differ from its debounced value before that value updates; legal range 2..2^CNT_W-1.
- CNT_W, 4: width of each per-channel stability counter.

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- BTN_WEST  input  1  raw west button, asynchronous.
- BTN_EAST  input  1  raw east button, asynchronous.
- SW  input  4  raw slide switches, asynchronous.
- west_level  output  1  debounced BTN_WEST.
- east_level  output  1  debounced BTN_EAST.
- west_press  output  1  one-cycle pulse on a west_level 0->1 transition.
- east_press  output  1  one-cycle pulse on an east_level 0->1 transition.
- sw_level  output  4  debounced SW.
- sw_change  output  1  one-cycle pulse when any sw_level bit changes.

## Operation

- Six identical channels: west, east, and SW[0]..SW[3].
- Each channel contains:
  - a 2-flop synchronizer, sync1 then sync2;
  - a CNT_W-bit counter cnt;
  - a debounced register db.
- Per cycle, each channel updates as follows:
  - If sync2 == db: cnt <= 0.
  - If sync2 != db and cnt < STABLE-1: cnt <= cnt+1.
  - If sync2 != db and cnt == STABLE-1: db <= sync2 and cnt <= 0.
- A mismatch that lasts fewer than STABLE consecutive cycles never reaches db. Any return to agreement restarts the count from 0.
- Press pulses:
  - west_press and east_press are registered.
  - Each is asserted in the same cycle its level first reads 1. It is high for exactly one cycle.
  - Falling edges produce no pulse.
- sw_change is registered and asserted for one cycle in the cycle sw_level first shows any new value. Several bits updating in the same cycle give one pulse. Bits updating in different cycles give separate pulses.
- Channels are fully independent, and simultaneous events on different channels are all reported.
- The counter never wraps: it saturates by construction at STABLE-1.

## Timing

- Reset (RST low): all flops clear immediately, independent of the clock.
  - Values cleared: sync1, sync2, cnt, db, and all pulse registers.
  - All outputs read 0 while RST is low.
- Reset mid-operation: any in-progress count is discarded.
  - If a raw input is high when RST releases, that line's level rises 2+STABLE cycles later.
  - Its press or sw_change pulse fires at that point.
- Latency: take a raw input change that meets setup before rising edge E0.
  - sync2 shows the new value after edge E1.
  - db and the associated pulse update after edge E1+STABLE.
  - Total is 2+STABLE edges (10 cycles = 200 ns at default).
- Minimum accepted pulse width: STABLE cycles as seen at sync2. Asynchronous inputs add ±1 cycle of sampling uncertainty.
- Pulses never span more than one cycle, even if the level stays high indefinitely.

## Test plan

- Reset: hold RST low with all raw inputs at 1 -> all outputs 0. Release RST -> west_level, east_level = 1 and sw_level = 4'hF after 10 cycles, each accompanied by exactly one west_press, east_press and sw_change pulse.
- Clean press: BTN_EAST high for 250 ns (12.5 cycles) -> east_level high for ~12-13 cycles starting 10 cycles after the rising edge. Exactly one east_press pulse. east_level returns to 0 about 10 cycles after the falling edge.
- Glitch rejection: BTN_WEST high for 100 ns (5 cycles) -> west_level stays 0, no west_press.
- Bounce: BTN_EAST toggles every 3 cycles for 60 cycles, then holds 1 -> exactly one east_press, occurring 10 cycles after the final rising edge.
- Switch change: SW 4'h0 -> 4'h1 for 2000 ns, then back to 4'h0 -> sw_level = 4'h1 after 10 cycles with one sw_change pulse. Returns to 4'h0 10 cycles after release with a second sw_change pulse.
- Simultaneous events: BTN_WEST and BTN_EAST rise on the same edge, together with SW 4'h0 -> 4'hA -> west_press, east_press and a single sw_change all assert in the same cycle, and sw_level = 4'hA.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces buttons and switches, emitting clean levels and one-cycle event pulses.
module input_conditioner #(
  parameter int STABLE = 8,
  parameter int CNT_W  = 4
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       BTN_WEST,
  input  logic       BTN_EAST,
  input  logic [3:0] SW,
  output logic       west_level,
  output logic       east_level,
  output logic       west_press,
  output logic       east_press,
  output logic [3:0] sw_level,
  output logic       sw_change
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
  logic [5:0]       w_raw;
  logic [5:0]       w_fire;
  logic [5:0]       r_sync1;
  logic [5:0]       r_sync2;
  logic [5:0]       r_db;
  logic [CNT_W-1:0] r_cnt [6];
  logic             r_west_press;
  logic             r_east_press;
  logic             r_sw_change;
  assign w_raw = {SW, BTN_EAST, BTN_WEST};
  // a channel fires on the edge where its mismatch has persisted STABLE cycles
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < 6; i++) w_fire[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == LAST);
  end
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_db         <= '0;
      r_west_press <= 1'b0;
      r_east_press <= 1'b0;
      r_sw_change  <= 1'b0;
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1      <= w_raw;
      r_sync2      <= r_sync1;
      r_db         <= r_db ^ w_fire;
      r_west_press <= w_fire[0] & r_sync2[0];
      r_east_press <= w_fire[1] & r_sync2[1];
      r_sw_change  <= |w_fire[5:2];
      for (int i = 0; i < 6; i++)
        r_cnt[i] <= (r_sync2[i] == r_db[i] || w_fire[i]) ? '0 : r_cnt[i] + CNT_W'(1);
    end
  end
  assign west_level = r_db[0];
  assign east_level = r_db[1];
  assign sw_level   = r_db[5:2];
  assign west_press = r_west_press;
  assign east_press = r_east_press;
  assign sw_change  = r_sw_change;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of reset, debounce latency, glitch/bounce rejection and event pulses.
module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_w = 1'b0;
  logic       btn_e = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       west_level, east_level, west_press, east_press, sw_change;
  logic [3:0] sw_level;
  int tests = 0;
  int fails = 0;
  int wp_n = 0, ep_n = 0, sc_n = 0, wl_n = 0;
  int wp0, ep0, sc0, wl0;
  input_conditioner dut (
    .CLK50MHZ(clk), .RST(rst_n), .BTN_WEST(btn_w), .BTN_EAST(btn_e), .SW(sw),
    .west_level(west_level), .east_level(east_level), .west_press(west_press),
    .east_press(east_press), .sw_level(sw_level), .sw_change(sw_change)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (west_press) wp_n++;
    if (east_press) ep_n++;
    if (sw_change) sc_n++;
    if (west_level) wl_n++;
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    wp0 = wp_n; ep0 = ep_n; sc0 = sc_n; wl0 = wl_n;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {26'd0, west_level, east_level, west_press, east_press, sw_change, 1'b0}, 32'd0);
    chk({tag, "_sw_level"}, {28'd0, sw_level}, 32'd0);
  endtask
  initial begin
    btn_w = 1'b1; btn_e = 1'b1; sw = 4'hF;
    step(3);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    snap();
    step(9);
    chk("rst_w_early", {31'd0, west_level}, 32'd0);
    chk("rst_sw_early", {28'd0, sw_level}, 32'd0);
    step(1);
    chk("rst_w_level", {31'd0, west_level}, 32'd1);
    chk("rst_e_level", {31'd0, east_level}, 32'd1);
    chk("rst_sw_level", {28'd0, sw_level}, 32'hF);
    chk("rst_pulses", {29'd0, west_press, east_press, sw_change}, 32'h7);
    step(1);
    chk("rst_pulses_1cyc", {29'd0, west_press, east_press, sw_change}, 32'h0);
    step(5);
    chk("rst_wp_count", wp_n - wp0, 32'd1);
    chk("rst_ep_count", ep_n - ep0, 32'd1);
    chk("rst_sc_count", sc_n - sc0, 32'd1);
    btn_w = 1'b0; btn_e = 1'b0; sw = 4'h0;
    snap();
    step(12);
    chk("fall_levels", {29'd0, west_level, east_level, 1'b0}, 32'd0);
    chk("fall_sw_level", {28'd0, sw_level}, 32'd0);
    chk("fall_no_press", (wp_n - wp0) + (ep_n - ep0), 32'd0);
    chk("fall_sc_count", sc_n - sc0, 32'd1);
    snap();
    btn_e = 1'b1;
    step(9);
    chk("press_e_early", {31'd0, east_level}, 32'd0);
    step(1);
    chk("press_e_level", {31'd0, east_level}, 32'd1);
    chk("press_e_pulse", {31'd0, east_press}, 32'd1);
    step(1);
    chk("press_e_pulse_end", {31'd0, east_press}, 32'd0);
    step(2);
    btn_e = 1'b0;
    step(9);
    chk("press_e_hold", {31'd0, east_level}, 32'd1);
    step(1);
    chk("press_e_release", {31'd0, east_level}, 32'd0);
    chk("press_e_no_fall_pulse", {31'd0, east_press}, 32'd0);
    step(3);
    chk("press_e_count", ep_n - ep0, 32'd1);
    snap();
    btn_w = 1'b1;
    step(5);
    btn_w = 1'b0;
    step(15);
    chk("glitch_w_level", {31'd0, west_level}, 32'd0);
    chk("glitch_w_never_high", wl_n - wl0, 32'd0);
    chk("glitch_w_no_press", wp_n - wp0, 32'd0);
    snap();
    for (int i = 0; i < 10; i++) begin
      btn_e = 1'b1;
      step(3);
      btn_e = 1'b0;
      step(3);
    end
    chk("bounce_no_press_yet", ep_n - ep0, 32'd0);
    chk("bounce_level_low", {31'd0, east_level}, 32'd0);
    btn_e = 1'b1;
    step(9);
    chk("bounce_early", {31'd0, east_level}, 32'd0);
    step(1);
    chk("bounce_level", {31'd0, east_level}, 32'd1);
    chk("bounce_press", {31'd0, east_press}, 32'd1);
    step(5);
    chk("bounce_press_count", ep_n - ep0, 32'd1);
    btn_e = 1'b0;
    step(12);
    snap();
    sw = 4'h1;
    step(9);
    chk("sw_early", {28'd0, sw_level}, 32'h0);
    step(1);
    chk("sw_set_level", {28'd0, sw_level}, 32'h1);
    chk("sw_set_change", {31'd0, sw_change}, 32'd1);
    step(1);
    chk("sw_set_change_end", {31'd0, sw_change}, 32'd0);
    step(89);
    sw = 4'h0;
    step(9);
    chk("sw_hold", {28'd0, sw_level}, 32'h1);
    step(1);
    chk("sw_clr_level", {28'd0, sw_level}, 32'h0);
    chk("sw_clr_change", {31'd0, sw_change}, 32'd1);
    step(3);
    chk("sw_change_count", sc_n - sc0, 32'd2);
    step(5);
    snap();
    btn_w = 1'b1; btn_e = 1'b1; sw = 4'hA;
    step(9);
    chk("sim_early", {29'd0, west_press, east_press, sw_change}, 32'h0);
    step(1);
    chk("sim_pulses", {29'd0, west_press, east_press, sw_change}, 32'h7);
    chk("sim_levels", {30'd0, west_level, east_level}, 32'h3);
    chk("sim_sw_level", {28'd0, sw_level}, 32'hA);
    step(1);
    chk("sim_pulses_end", {29'd0, west_press, east_press, sw_change}, 32'h0);
    step(3);
    chk("sim_sc_count", sc_n - sc0, 32'd1);
    #5 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    step(2);
    rst_n = 1'b1;
    snap();
    step(9);
    chk("rerst_early", {30'd0, west_level, east_level}, 32'h0);
    step(1);
    chk("rerst_levels", {30'd0, west_level, east_level}, 32'h3);
    chk("rerst_sw_level", {28'd0, sw_level}, 32'hA);
    chk("rerst_pulses", {29'd0, west_press, east_press, sw_change}, 32'h7);
    step(5);
    chk("rerst_counts", (wp_n - wp0) + (ep_n - ep0) + (sc_n - sc0), 32'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
